// File: rtl/riscp_pkg.sv
// rtl/riscp_pkg.sv - shared register-file constants and writeback request type
package riscp_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 8;

  // One writeback request as presented by a pipeline stage
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regbank_write_ctrl_if.sv
// rtl/regbank_write_ctrl_if.sv - writeback, reservation, hazard and bank-write signals
interface regbank_write_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  // Writeback requester 0 (execute/ALU)
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;

  // Writeback requester 1 (memory/load)
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  // Decode-side reservation and hazard query
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ready;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              stall;

  // Register bank write port and scoreboard error flag
  logic              write;
  logic [ADDR_W-1:0] writeAdd;
  logic [DATA_W-1:0] in;
  logic              sb_err;

  // Pipeline side: writeback stages plus decode
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output rsv_valid, rsv_addr,
    input  rsv_ready,
    output rd_addr1, rd_addr2,
    input  stall,
    input  write, writeAdd, in, sb_err
  );

  // Write controller side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  rsv_valid, rsv_addr,
    output rsv_ready,
    input  rd_addr1, rd_addr2,
    output stall,
    output write, writeAdd, in, sb_err
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way writeback arbiter; ROUND_ROBIN_EN selects round-robin, else req1 fixed priority
module rr_arb2 (
`ifdef ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

`ifdef ROUND_ROBIN_EN
  // ptr==0 favours req0 on contention, ptr==1 favours req1
  logic ptr;

  // Pointer flips only on a contended cycle, so a lone requester never moves it
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (valid0 && valid1) begin
      ptr <= ~ptr;
    end
  end

  // Contended cycles go to the pointed-at side; otherwise whoever is valid wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (valid0 && valid1) begin
      grant0 = ~ptr;
      grant1 = ptr;
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
  end
`else
  // Loads always win so memory results never back up behind ALU results
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    grant1 = valid1;
    grant0 = valid0 & ~valid1;
  end
`endif

endmodule

// File: rtl/regbank_write_ctrl.sv
// rtl/regbank_write_ctrl.sv - register bank write sequencer with pending-write scoreboard (ROUND_ROBIN_EN: round-robin arbitration)
module regbank_write_ctrl
  import riscp_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regbank_write_ctrl_if.slave  bus
);

  localparam int              NUM     = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_req_t req0;
  wb_req_t req1;
  wb_req_t selReq;
  logic    grant0;
  logic    grant1;
  logic    accept;

  logic              writeReg;
  logic [ADDR_W-1:0] writeAddReg;
  logic [DATA_W-1:0] inReg;
  logic              sbErrReg;

  logic [CNT_W-1:0] cnt [NUM];
  logic [NUM-1:0]   incVec;
  logic [NUM-1:0]   decVec;
  logic             rsvFire;
  logic             underflow;

  assign req0 = '{valid: bus.req0_valid, addr: bus.req0_addr, data: bus.req0_data};
  assign req1 = '{valid: bus.req1_valid, addr: bus.req1_addr, data: bus.req1_data};

`ifdef ROUND_ROBIN_EN
  rr_arb2 arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );
`else
  rr_arb2 arb (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );
`endif

  assign bus.req0_ready = req0.valid & grant0;
  assign bus.req1_ready = req1.valid & grant1;

  assign selReq = grant1 ? req1 : req0;
  assign accept = selReq.valid & (grant0 | grant1);

  // Bank write register: one-cycle latency from accept, dropped by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      writeReg    <= 1'b0;
      writeAddReg <= '0;
      inReg       <= '0;
    end else begin
      writeReg <= accept;
      if (accept) begin
        writeAddReg <= selReq.addr;
        inReg       <= selReq.data;
      end
    end
  end

  assign bus.write    = writeReg;
  assign bus.writeAdd = writeAddReg;
  assign bus.in       = inReg;

  // A reservation is refused while its counter is saturated
  assign bus.rsv_ready = (cnt[bus.rsv_addr] != CNT_MAX);
  assign rsvFire       = bus.rsv_valid & bus.rsv_ready;

  // Decode the per-register increment (reservation) and decrement (commit) strobes
  always_comb begin
    incVec = '0;
    decVec = '0;
    if (rsvFire) begin
      incVec[bus.rsv_addr] = 1'b1;
    end
    if (writeReg) begin
      decVec[writeAddReg] = 1'b1;
    end
  end

  // A commit to an idle register underflows unless a reservation lands on it the same cycle
  assign underflow = writeReg && (cnt[writeAddReg] == '0) && !incVec[writeAddReg];

  // Pending-write counters: reserve and commit together cancel out, underflow saturates at 0
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM; i++) begin
      if (!reset) begin
        cnt[i] <= '0;
      end else if (incVec[i] && !decVec[i]) begin
        cnt[i] <= cnt[i] + CNT_ONE;
      end else if (decVec[i] && !incVec[i] && (cnt[i] != '0)) begin
        cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  // Sticky scoreboard error, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      sbErrReg <= 1'b0;
    end else if (underflow) begin
      sbErrReg <= 1'b1;
    end
  end

  assign bus.sb_err = sbErrReg;

  // No bypass: hazard is judged on the counts as they stand this cycle
  assign bus.stall = (cnt[bus.rd_addr1] != '0) | (cnt[bus.rd_addr2] != '0);

endmodule

// File: tb/tb_regbank_write_ctrl.sv
// tb/tb_regbank_write_ctrl.sv - scoreboard bench for regbank_write_ctrl
module tb_regbank_write_ctrl;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t expQ[$];

  regbank_write_ctrl_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regbank_write_ctrl #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.rsv_valid  = 1'b0; bus.rsv_addr  = '0;
    bus.rd_addr1   = '0;   bus.rd_addr2  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    cyc();
    cyc();
    total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL rst_write: got %0b want 0", bus.write); end
    total++; if (bus.writeAdd !== 3'd0) begin bad++; $display("FAIL rst_writeAdd: got %0d want 0", bus.writeAdd); end
    total++; if (bus.in !== 16'h0) begin bad++; $display("FAIL rst_in: got %h want 0000", bus.in); end
    total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL rst_sb_err: got %0b want 0", bus.sb_err); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b want 0", bus.stall); end
    for (int a = 0; a < 8; a++) begin
      bus.rsv_addr = 3'(a);
      #1;
      total++; if (bus.rsv_ready !== 1'b1) begin bad++; $display("FAIL rst_rsv_ready[%0d]: got %0b want 1", a, bus.rsv_ready); end
    end
    bus.rsv_addr = '0;
    reset = 1'b1;
    expQ.delete();
  endtask

  task automatic test_basic();
    exp_t e;
    for (int ph = 0; ph < 4; ph++) begin
      cyc();
      if (expQ.size() != 0) begin
        e = expQ.pop_front(); total++;
        if (bus.write !== 1'b1 || bus.writeAdd !== e.addr || bus.in !== e.data) begin
          bad++; $display("FAIL basic_wb: got write=%0b addr=%0d data=%h want 1/%0d/%h", bus.write, bus.writeAdd, bus.in, e.addr, e.data);
        end
      end else begin
        total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL basic_idle: got write=%0b want 0", bus.write); end
      end
      case (ph)
        0: begin
          bus.rsv_valid = 1'b1; bus.rsv_addr = 3'd3; bus.rd_addr1 = 3'd3;
          #1;
          total++; if (bus.rsv_ready !== 1'b1) begin bad++; $display("FAIL basic_rsv_ready: got %0b want 1", bus.rsv_ready); end
          total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL basic_stall_pre: got %0b want 0", bus.stall); end
        end
        1: begin
          bus.rsv_valid = 1'b0;
          bus.req0_valid = 1'b1; bus.req0_addr = 3'd3; bus.req0_data = 16'h1234;
          #1;
          total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL basic_stall_pend: got %0b want 1", bus.stall); end
          total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL basic_req0_ready: got %0b want 1", bus.req0_ready); end
          expQ.push_back('{addr: 3'd3, data: 16'h1234});
        end
        2: begin
          bus.req0_valid = 1'b0;
          #1;
          total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL basic_stall_commit: got %0b want 1", bus.stall); end
        end
        default: begin
          #1;
          total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL basic_stall_after: got %0b want 0", bus.stall); end
        end
      endcase
    end
    idle();
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int ph = 0; ph < 6; ph++) begin
      cyc();
      if (expQ.size() != 0) begin
        e = expQ.pop_front(); total++;
        if (bus.write !== 1'b1 || bus.writeAdd !== e.addr || bus.in !== e.data) begin
          bad++; $display("FAIL sat_wb: got write=%0b addr=%0d data=%h want 1/%0d/%h", bus.write, bus.writeAdd, bus.in, e.addr, e.data);
        end
      end else begin
        total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL sat_idle: got write=%0b want 0", bus.write); end
      end
      bus.rsv_addr = 3'd5; bus.rd_addr1 = 3'd5;
      if (ph < 3) begin
        bus.rsv_valid = 1'b1;
        #1;
        total++; if (bus.rsv_ready !== 1'b1) begin bad++; $display("FAIL sat_rsv%0d: got %0b want 1", ph, bus.rsv_ready); end
      end else if (ph == 3) begin
        bus.rsv_valid = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd5; bus.req0_data = 16'h5555;
        #1;
        total++; if (bus.rsv_ready !== 1'b0) begin bad++; $display("FAIL sat_full: got %0b want 0", bus.rsv_ready); end
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL sat_stall: got %0b want 1", bus.stall); end
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL sat_req0_ready: got %0b want 1", bus.req0_ready); end
        expQ.push_back('{addr: 3'd5, data: 16'h5555});
      end else if (ph == 4) begin
        bus.req0_valid = 1'b0;
        #1;
        total++; if (bus.rsv_ready !== 1'b0) begin bad++; $display("FAIL sat_full_commit: got %0b want 0", bus.rsv_ready); end
      end else begin
        bus.rsv_valid = 1'b0;
        #1;
        total++; if (bus.rsv_ready !== 1'b1) begin bad++; $display("FAIL sat_freed: got %0b want 1", bus.rsv_ready); end
      end
    end
    idle();
  endtask

  task automatic test_err();
    exp_t e;
    for (int ph = 0; ph < 7; ph++) begin
      cyc();
      if (expQ.size() != 0) begin
        e = expQ.pop_front(); total++;
        if (bus.write !== 1'b1 || bus.writeAdd !== e.addr || bus.in !== e.data) begin
          bad++; $display("FAIL err_wb: got write=%0b addr=%0d data=%h want 1/%0d/%h", bus.write, bus.writeAdd, bus.in, e.addr, e.data);
        end
      end else begin
        total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL err_idle: got write=%0b want 0", bus.write); end
      end
      case (ph)
        0: begin
          total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %0b want 0", bus.sb_err); end
          bus.req0_valid = 1'b1; bus.req0_addr = 3'd2; bus.req0_data = 16'h2222;
          #1;
          total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL err_req0_ready: got %0b want 1", bus.req0_ready); end
          expQ.push_back('{addr: 3'd2, data: 16'h2222});
        end
        1: begin
          bus.req0_valid = 1'b0;
        end
        2: begin
          total++; if (bus.sb_err !== 1'b1) begin bad++; $display("FAIL err_set: got %0b want 1", bus.sb_err); end
          bus.rsv_valid = 1'b1; bus.rsv_addr = 3'd4;
          bus.req1_valid = 1'b1; bus.req1_addr = 3'd4; bus.req1_data = 16'h4444;
          #1;
          total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL err_req1_ready_a: got %0b want 1", bus.req1_ready); end
          expQ.push_back('{addr: 3'd4, data: 16'h4444});
        end
        3: begin
          bus.req1_valid = 1'b0;
          #1;
          total++; if (bus.rsv_ready !== 1'b1) begin bad++; $display("FAIL err_rsv_same: got %0b want 1", bus.rsv_ready); end
          total++; if (bus.sb_err !== 1'b1) begin bad++; $display("FAIL err_hold_a: got %0b want 1", bus.sb_err); end
        end
        4: begin
          bus.rsv_valid = 1'b0; bus.rd_addr1 = 3'd4;
          bus.req1_valid = 1'b1; bus.req1_addr = 3'd4; bus.req1_data = 16'h4445;
          #1;
          total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL err_same_cycle_cnt: got stall %0b want 1", bus.stall); end
          total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL err_req1_ready_b: got %0b want 1", bus.req1_ready); end
          expQ.push_back('{addr: 3'd4, data: 16'h4445});
        end
        5: begin
          bus.req1_valid = 1'b0;
          #1;
          total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL err_stall_commit: got %0b want 1", bus.stall); end
        end
        default: begin
          #1;
          total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL err_stall_done: got %0b want 0", bus.stall); end
          total++; if (bus.sb_err !== 1'b1) begin bad++; $display("FAIL err_hold_b: got %0b want 1", bus.sb_err); end
        end
      endcase
    end
    idle();
  endtask

  task automatic test_arb();
    exp_t        e;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        g1;
    logic        ptr;
    d0  = 16'hA000;
    d1  = 16'hB000;
    ptr = 1'b0;
    for (int ph = 0; ph < 10; ph++) begin
      cyc();
      if (expQ.size() != 0) begin
        e = expQ.pop_front(); total++;
        if (bus.write !== 1'b1 || bus.writeAdd !== e.addr || bus.in !== e.data) begin
          bad++; $display("FAIL arb_wb%0d: got write=%0b addr=%0d data=%h want 1/%0d/%h", ph, bus.write, bus.writeAdd, bus.in, e.addr, e.data);
        end
      end else begin
        total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL arb_idle%0d: got write=%0b want 0", ph, bus.write); end
      end
      if (ph < 8) begin
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = d0;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = d1;
`ifdef ROUND_ROBIN_EN
        g1  = ptr;
        ptr = ~ptr;
`else
        g1 = 1'b1;
`endif
        #1;
        total++;
        if (bus.req0_ready !== ~g1 || bus.req1_ready !== g1) begin
          bad++; $display("FAIL arb_grant%0d: got ready0=%0b ready1=%0b want %0b/%0b", ph, bus.req0_ready, bus.req1_ready, ~g1, g1);
        end
        if (g1) begin
          expQ.push_back('{addr: 3'd2, data: d1});
          d1 = d1 + 16'd1;
        end else begin
          expQ.push_back('{addr: 3'd1, data: d0});
          d0 = d0 + 16'd1;
        end
      end else begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int ph = 0; ph < 3; ph++) begin
      cyc();
      if (expQ.size() != 0) begin
        e = expQ.pop_front(); total++;
        if (bus.write !== 1'b1 || bus.writeAdd !== e.addr || bus.in !== e.data) begin
          bad++; $display("FAIL mid_wb: got write=%0b addr=%0d data=%h want 1/%0d/%h", bus.write, bus.writeAdd, bus.in, e.addr, e.data);
        end
      end else begin
        total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL mid_idle%0d: got write=%0b want 0", ph, bus.write); end
      end
      if (ph == 0) begin
        bus.rsv_valid = 1'b1; bus.rsv_addr = 3'd6;
      end else if (ph == 1) begin
        bus.rsv_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd6; bus.req0_data = 16'h6666;
        reset = 1'b0;
      end else begin
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        total++; if (bus.writeAdd !== 3'd0 || bus.in !== 16'h0) begin bad++; $display("FAIL mid_outreg: got addr=%0d data=%h want 0/0000", bus.writeAdd, bus.in); end
        total++; if (bus.sb_err !== 1'b0) begin bad++; $display("FAIL mid_sb_err: got %0b want 0", bus.sb_err); end
        for (int a = 0; a < 8; a++) begin
          bus.rd_addr1 = 3'(a); bus.rd_addr2 = 3'(a); bus.rsv_addr = 3'(a);
          #1;
          total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL mid_stall[%0d]: got %0b want 0", a, bus.stall); end
          total++; if (bus.rsv_ready !== 1'b1) begin bad++; $display("FAIL mid_rsv_ready[%0d]: got %0b want 1", a, bus.rsv_ready); end
        end
      end
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_saturate();
    test_err();
    test_arb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
